// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side bus bundle of the two-port memory arbiter.
interface mem_arbiter_if #(parameter int ADDR_W = 6);
  logic req0, req1, we0, we1;
  logic [31:0] adr0, adr1, wdata0, wdata1;
  logic gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [31:0] mem_wdata, mem_rdata;
  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           mem_en, mem_we, mem_adr, mem_wdata
  );
  modport master (
    output req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
           mem_en, mem_we, mem_adr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter sequencing one fixed-latency single-port memory.
// Define MEMARB_RANGE_CHECK_EN to flag out-of-range addresses instead of wrapping them.
module mem_arbiter #(
  parameter int DEPTH   = 64,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic r_rr, r_id, r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [31:0] r_wdata, r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic w_idle, w_gnt0, w_gnt1, w_gnt, w_oor, w_last, w_issue, w_resp, w_unused;
  logic [31:0] w_adr;
  // gnt is combinational and suppressed during reset so every output reads 0 then
  assign w_idle = r_state == IDLE && !reset;
  assign w_gnt0 = w_idle && bus.req0 && (!bus.req1 || !r_rr);
  assign w_gnt1 = w_idle && bus.req1 && (!bus.req0 || r_rr);
  assign w_gnt  = w_gnt0 || w_gnt1;
  assign w_adr  = w_gnt1 ? bus.adr1 : bus.adr0;
  assign w_last = r_cnt == CNT_W'(1);
`ifdef MEMARB_RANGE_CHECK_EN
  logic r_err;
  assign w_oor    = |w_adr[31:ADDR_W+2];
  assign w_unused = ^w_adr[1:0];
`else
  assign w_oor    = 1'b0;
  assign w_unused = ^{w_adr[31:ADDR_W+2], w_adr[1:0]};
`endif
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE  ? (w_gnt ? (w_oor ? RESP : ISSUE) : IDLE) :
             r_state == ISSUE ? WAIT :
             r_state == WAIT  ? (w_last ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr    <= 1'b0;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
`ifdef MEMARB_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      if (w_gnt) begin
        r_rr    <= w_gnt0;
        r_id    <= w_gnt1;
        r_we    <= w_gnt1 ? bus.we1 : bus.we0;
        r_adr   <= w_adr[ADDR_W+1:2];
        r_wdata <= w_gnt1 ? bus.wdata1 : bus.wdata0;
        r_rdata <= '0;
`ifdef MEMARB_RANGE_CHECK_EN
        r_err   <= w_oor;
`endif
      end
      if (r_state == ISSUE) r_cnt <= CNT_W'(MEM_LAT);
      else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) r_rdata <= r_we ? '0 : bus.mem_rdata;
      end
    end
  end
  assign w_issue = r_state == ISSUE;
  assign w_resp  = r_state == RESP;
  always_comb begin
    bus.gnt0      = w_gnt0;
    bus.gnt1      = w_gnt1;
    bus.done0     = w_resp && !r_id;
    bus.done1     = w_resp && r_id;
    bus.rdata0    = (w_resp && !r_id) ? r_rdata : '0;
    bus.rdata1    = (w_resp && r_id) ? r_rdata : '0;
`ifdef MEMARB_RANGE_CHECK_EN
    bus.err0      = w_resp && !r_id && r_err;
    bus.err1      = w_resp && r_id && r_err;
`else
    bus.err0      = 1'b0;
    bus.err1      = 1'b0;
`endif
    bus.mem_en    = w_issue;
    bus.mem_we    = w_issue && r_we;
    bus.mem_adr   = w_issue ? r_adr : '0;
    bus.mem_wdata = w_issue ? r_wdata : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with DEPTH=64, MEM_LAT=2 and a behavioural memory.
module tb_mem_arbiter;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  logic clk = 1'b0;
  logic reset;
  int nvec = 0;
  int nfail = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] d1, d2;
  mem_arbiter_if #(.ADDR_W(6)) bus();
  mem_arbiter #(.DEPTH(DEPTH), .MEM_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reset) begin
      mem[0] <= 32'hA5A5_0000;
      mem[4] <= 32'hDEAD_BEEF;
    end else if (bus.mem_en && bus.mem_we) mem[bus.mem_adr] <= bus.mem_wdata;
    d1 <= mem[bus.mem_adr];
    d2 <= d1;
  end
  assign bus.mem_rdata = d2;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nvec++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic idle();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.adr0 = 0; bus.adr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
  endtask
  task automatic quiet(input string tag);
    chk({tag, "_ctl"}, {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.mem_en, bus.mem_we}, 0);
    chk({tag, "_dat"}, bus.rdata0 | bus.rdata1 | bus.mem_wdata | 32'(bus.mem_adr), 0);
  endtask
  task automatic xact(input string tag, input bit p, input bit we, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [31:0] rd, input int wadr);
    if (p) begin bus.req1 = 1; bus.we1 = we; bus.adr1 = adr; bus.wdata1 = wd; end
    else   begin bus.req0 = 1; bus.we0 = we; bus.adr0 = adr; bus.wdata0 = wd; end
    smp();
    chk({tag, "_gnt"}, {bus.gnt0, bus.gnt1}, p ? 2'b01 : 2'b10);
    cyc(); idle(); smp();
    chk({tag, "_issue"}, {bus.mem_en, bus.mem_we}, {1'b1, we});
    chk({tag, "_madr"}, 32'(bus.mem_adr), wadr);
    chk({tag, "_mwd"}, bus.mem_wdata, we ? wd : 0);
    for (int i = 0; i < LAT; i++) begin
      cyc(); smp();
      chk({tag, "_wait"}, {bus.mem_en, bus.mem_we, bus.done0, bus.done1}, 0);
      chk({tag, "_wait_wd"}, bus.mem_wdata, 0);
    end
    cyc(); smp();
    chk({tag, "_done"}, {bus.done0, bus.done1, bus.err0, bus.err1}, p ? 4'b0100 : 4'b1000);
    chk({tag, "_rd"}, p ? bus.rdata1 : bus.rdata0, rd);
    chk({tag, "_rd_other"}, p ? bus.rdata0 : bus.rdata1, 0);
    cyc(); smp();
    quiet({tag, "_post"});
    cyc();
  endtask
  initial begin
    idle();
    reset = 1;
    cyc(); cyc();
    bus.req0 = 1; bus.req1 = 1;
    smp();
    quiet("reset");
    cyc();
    reset = 0;
    idle();
    xact("t1", 0, 0, 32'h10, 0, 32'hDEAD_BEEF, 4);
    xact("t2w", 1, 1, 32'h20, 32'h1234_5678, 0, 8);
    xact("t2r", 1, 0, 32'h20, 0, 32'h1234_5678, 8);
    // contention: both ports held from reset, each transaction spans LAT+3 cycles
    reset = 1;
    bus.req0 = 1; bus.adr0 = 32'h10; bus.req1 = 1; bus.adr1 = 32'h20;
    cyc();
    reset = 0;
    for (int c = 0; c < 20; c++) begin
      int k, ph;
      k = c / 5; ph = c % 5;
      smp();
      chk("cont_gnt", {bus.gnt0, bus.gnt1}, ph == 0 ? (k % 2 == 0 ? 2'b10 : 2'b01) : 2'b00);
      chk("cont_done", {bus.done0, bus.done1}, ph == 4 ? (k % 2 == 0 ? 2'b10 : 2'b01) : 2'b00);
      chk("cont_en", bus.mem_en, ph == 1);
      chk("cont_rd0", bus.rdata0, (ph == 4 && k % 2 == 0) ? 32'hDEAD_BEEF : 0);
      chk("cont_rd1", bus.rdata1, (ph == 4 && k % 2 == 1) ? 32'h1234_5678 : 0);
      cyc();
    end
    idle();
    cyc();
    bus.req1 = 1; bus.adr1 = 32'h20;
    smp();
    chk("rst1_gnt", {bus.gnt0, bus.gnt1}, 2'b01);
    cyc(); idle();
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    smp();
    quiet("rst1_after");
    cyc(); smp();
    quiet("rst1_nodone");
    cyc(); cyc();
    // port 0 granted leaves the pointer at 1; reset must restore port-0 priority
    bus.req0 = 1; bus.adr0 = 32'h10;
    smp();
    chk("rst0_gnt", {bus.gnt0, bus.gnt1}, 2'b10);
    cyc(); idle();
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    bus.req0 = 1; bus.adr0 = 32'h10; bus.req1 = 1; bus.adr1 = 32'h20;
    smp();
    chk("rst_ptr", {bus.gnt0, bus.gnt1}, 2'b10);
    cyc(); idle();
    cyc(); cyc(); cyc();
    smp();
    chk("rst_ptr_done", {bus.done0, bus.done1}, 2'b10);
    cyc(); cyc();
    bus.req0 = 1; bus.adr0 = 32'h10;
    smp();
    chk("drop_gnt0", {bus.gnt0, bus.gnt1}, 2'b10);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 1) idle();
      bus.req1 = (c == 2);
      bus.adr1 = (c == 2) ? 32'h20 : 0;
      smp();
      chk("drop_p1", {bus.gnt1, bus.done1}, 0);
      chk("drop_en", bus.mem_en, c == 1);
      chk("drop_done0", bus.done0, c == 4);
    end
    cyc();
`ifdef MEMARB_RANGE_CHECK_EN
    bus.req0 = 1; bus.adr0 = 32'h100;
    smp();
    chk("range_gnt", {bus.gnt0, bus.gnt1, bus.mem_en}, 3'b100);
    cyc(); idle(); smp();
    chk("range_done", {bus.done0, bus.err0, bus.done1, bus.err1, bus.mem_en}, 5'b11000);
    chk("range_rd", bus.rdata0, 0);
    cyc(); smp();
    quiet("range_post");
    cyc();
`else
    xact("wrap", 0, 0, 32'h100, 0, 32'hA5A5_0000, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
